rab_cfg_regs: RTL and testbench
===============================

RAB_CFG_REGS -- requirements
Module: rab_cfg_regs

Interface
REQ-001 Parameter N_SLICES, default 4: number of translation slices programmed (1..16).
REQ-002 Parameter ADDR_W, default 8: AXI4-Lite address width.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_W/1/1  write-address channel.
REQ-006 s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1  write-data channel.
REQ-007 s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  write-response channel.
REQ-008 s_araddr/s_arvalid/s_arready  in/in/out  ADDR_W/1/1  read-address channel.
REQ-009 s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1  read-data channel.
REQ-010 cfg_min, cfg_max, cfg_offset  out  N_SLICES*32 each  per-slice bounds and offset; slice i occupies bits [32i+31:32i].
REQ-011 cfg_en, cfg_ren, cfg_wen  out  N_SLICES each  per-slice enable, read permit, write permit.

Function
REQ-012 Address decode: slice = addr[ADDR_W-1:4], reg = addr[3:2], addr[1:0] ignored; reg 0 = MIN, 1 = MAX, 2 = OFFSET, 3 = FLAGS {bit2 wen, bit1 ren, bit0 en}, other FLAGS bits read 0 and ignore writes.
REQ-013 slice >= N_SLICES is a decode error: write has no effect, resp = SLVERR (2'b10); read returns rdata 0, resp SLVERR; valid decodes return OKAY (2'b00).
REQ-014 Write FSM states: W_IDLE, W_RESP.
REQ-015 In W_IDLE, s_awready and s_wready are each 1 until their own beat is captured; AW and W are accepted independently, in either order or the same cycle; each is latched and its ready drops after capture.
REQ-016 When both AW and W are captured (at the latest in the later acceptance cycle), the register write commits on that clock edge, byte-masked by s_wstrb; FSM enters W_RESP with s_bvalid=1 the next cycle.
REQ-017 In W_RESP, s_bvalid holds with stable s_bresp until s_bready=1; on that edge, go to W_IDLE with both readies 1 the next cycle; at most one write outstanding.
REQ-018 Read FSM states: R_IDLE (s_arready=1), R_DATA (s_rvalid=1); an AR handshake captures rdata/rresp from current register contents and enters R_DATA; s_rvalid, s_rdata, s_rresp hold stable until s_rready=1, then return to R_IDLE.
REQ-019 Read and write FSMs are independent and may be active simultaneously.
REQ-020 Same-cycle write commit and AR handshake to the same register: read returns the pre-write value.
REQ-021 cfg_* outputs are driven directly from the registers: updated value is visible the cycle after the commit edge, with no other latency.
REQ-022 No ordering or range check between MIN and MAX; software is responsible for consistency.
REQ-023 Any wstrb, including 4'b0000, produces a response; 0000 changes nothing.

Reset
REQ-024 While rst=1 at a clock edge: all MIN/MAX/OFFSET = 0, all en/ren/wen = 0, both FSMs idle, s_bvalid = s_rvalid = 0, s_awready = s_wready = s_arready = 1 from the first cycle after reset, s_rdata = 0, responses = OKAY.
REQ-025 Reset mid-transaction abandons it: a latched uncommitted AW or W is discarded, a pending B or R response is dropped, and a committed write is also cleared to 0.

Verification
REQ-026 AW 0x14 and W 0xDEAD_BEEF, strb 1111, same cycle -> cfg_max[63:32] = 0xDEADBEEF the cycle after commit; bvalid with OKAY; read 0x14 returns 0xDEADBEEF.
REQ-027 W arrives 3 cycles before AW 0x0C, data 0x5, strb 0001 -> wready low after W capture; slice0 en=1, ren=0, wen=1 after AW capture; bresp OKAY.
REQ-028 Write 0x08 = 0xFFFFFFFF, then strb 0010 with data 0x0000_1200 -> cfg_offset[31:0] = 0xFFFF12FF.
REQ-029 N_SLICES=4: write 0x40, then read 0x40 -> bresp SLVERR with no cfg change; rdata 0, rresp SLVERR.
REQ-030 bready and rready held low 5 cycles during concurrent write and read to 0x00 -> bvalid, rvalid and data stable all 5 cycles; rdata is the pre-write value; no new AW/AR accepted until the responses complete.
REQ-031 rst asserted while in W_RESP with registers programmed -> next cycle bvalid=0, all cfg outputs 0, readies 1.

Source files
------------

// File: rtl/rab_cfg_regs.sv
// AXI4-Lite register file holding per-slice MIN/MAX/OFFSET/FLAGS for the remap
// address block. The write and read channels are served by independent FSMs.
module rab_cfg_regs #(
  parameter int unsigned N_SLICES = 4,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [N_SLICES*32-1:0] cfg_min,
  output logic [N_SLICES*32-1:0] cfg_max,
  output logic [N_SLICES*32-1:0] cfg_offset,
  output logic [N_SLICES-1:0]   cfg_en,
  output logic [N_SLICES-1:0]   cfg_ren,
  output logic [N_SLICES-1:0]   cfg_wen
);

  localparam int unsigned SlW = ADDR_W - 4;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_W-1:2] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [31:0] min_q [N_SLICES];
  logic [31:0] min_d [N_SLICES];
  logic [31:0] max_q [N_SLICES];
  logic [31:0] max_d [N_SLICES];
  logic [31:0] off_q [N_SLICES];
  logic [31:0] off_d [N_SLICES];
  logic [2:0]  flg_q [N_SLICES];
  logic [2:0]  flg_d [N_SLICES];

  logic              aw_hs, w_hs, ar_hs, commit, wr_err, rd_err;
  logic [ADDR_W-1:2] waddr;
  logic [31:0]       wdata, wmask, rd_val;
  logic [3:0]        wstrb;
  logic [SlW-1:0]    wslice, rslice;
  logic [1:0]        wreg, rreg;
  logic              unused_addr;

  assign unused_addr = ^{s_awaddr[1:0], s_araddr[1:0]};

  // Write channel: AW and W latch independently, commit once both are held.
  always_comb begin
    s_awready = (w_state_q == WIdle) && !aw_got_q;
    s_wready  = (w_state_q == WIdle) && !w_got_q;
    s_bvalid  = (w_state_q == WResp);
    s_bresp   = bresp_q;
    aw_hs     = s_awvalid && s_awready;
    w_hs      = s_wvalid && s_wready;
    waddr     = aw_got_q ? awaddr_q : s_awaddr[ADDR_W-1:2];
    wdata     = w_got_q ? wdata_q : s_wdata;
    wstrb     = w_got_q ? wstrb_q : s_wstrb;
    wmask     = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    wslice    = waddr[ADDR_W-1:4];
    wreg      = waddr[3:2];
    wr_err    = 32'(wslice) >= N_SLICES;
    commit    = (w_state_q == WIdle) && (aw_got_q || aw_hs) && (w_got_q || w_hs);

    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_got_d = 1'b1;
      awaddr_d = s_awaddr[ADDR_W-1:2];
    end
    if (w_hs) begin
      w_got_d = 1'b1;
      wdata_d = s_wdata;
      wstrb_d = s_wstrb;
    end
    if (commit) begin
      aw_got_d  = 1'b0;
      w_got_d   = 1'b0;
      bresp_d   = wr_err ? 2'b10 : 2'b00;
      w_state_d = WResp;
    end
    if ((w_state_q == WResp) && s_bready) w_state_d = WIdle;
  end

  always_comb begin
    for (int unsigned i = 0; i < N_SLICES; i++) begin
      min_d[i] = min_q[i];
      max_d[i] = max_q[i];
      off_d[i] = off_q[i];
      flg_d[i] = flg_q[i];
      if (commit && !wr_err && (wslice == SlW'(i))) begin
        unique case (wreg)
          2'd0: min_d[i] = (min_q[i] & ~wmask) | (wdata & wmask);
          2'd1: max_d[i] = (max_q[i] & ~wmask) | (wdata & wmask);
          2'd2: off_d[i] = (off_q[i] & ~wmask) | (wdata & wmask);
          2'd3: flg_d[i] = (flg_q[i] & ~wmask[2:0]) | (wdata[2:0] & wmask[2:0]);
          default: ;
        endcase
      end
    end
  end

  // Read channel samples the _q registers, so a same-cycle commit is not seen.
  always_comb begin
    s_arready = (r_state_q == RIdle);
    s_rvalid  = (r_state_q == RData);
    s_rdata   = rdata_q;
    s_rresp   = rresp_q;
    ar_hs     = s_arvalid && s_arready;
    rslice    = s_araddr[ADDR_W-1:4];
    rreg      = s_araddr[3:2];
    rd_err    = 32'(rslice) >= N_SLICES;
    rd_val    = '0;
    for (int unsigned i = 0; i < N_SLICES; i++) begin
      if (rslice == SlW'(i)) begin
        unique case (rreg)
          2'd0: rd_val = min_q[i];
          2'd1: rd_val = max_q[i];
          2'd2: rd_val = off_q[i];
          2'd3: rd_val = {29'd0, flg_q[i]};
          default: ;
        endcase
      end
    end

    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ar_hs) begin
      rdata_d   = rd_err ? 32'd0 : rd_val;
      rresp_d   = rd_err ? 2'b10 : 2'b00;
      r_state_d = RData;
    end
    if ((r_state_q == RData) && s_rready) r_state_d = RIdle;
  end

  always_comb begin
    for (int unsigned i = 0; i < N_SLICES; i++) begin
      cfg_min[32*i +: 32]    = min_q[i];
      cfg_max[32*i +: 32]    = max_q[i];
      cfg_offset[32*i +: 32] = off_q[i];
      cfg_en[i]              = flg_q[i][0];
      cfg_ren[i]             = flg_q[i][1];
      cfg_wen[i]             = flg_q[i][2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= 2'b00;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      for (int unsigned i = 0; i < N_SLICES; i++) begin
        min_q[i] <= '0;
        max_q[i] <= '0;
        off_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      for (int unsigned i = 0; i < N_SLICES; i++) begin
        min_q[i] <= min_d[i];
        max_q[i] <= max_d[i];
        off_q[i] <= off_d[i];
        flg_q[i] <= flg_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rab_cfg_regs.sv
// Directed bench for rab_cfg_regs: ordered AW/W arrival, strobes, decode errors,
// back-pressure on B/R and reset in the middle of transactions.
module tb_rab_cfg_regs;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_awaddr, s_araddr;
  logic         s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic         s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0]  s_wdata, s_rdata;
  logic [3:0]   s_wstrb;
  logic [1:0]   s_bresp, s_rresp;
  logic [127:0] cfg_min, cfg_max, cfg_offset;
  logic [3:0]   cfg_en, cfg_ren, cfg_wen;

  int checks = 0;
  int errors = 0;

  rab_cfg_regs #(.N_SLICES(4), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_offset(cfg_offset),
    .cfg_en(cfg_en), .cfg_ren(cfg_ren), .cfg_wen(cfg_wen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input string tag, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp);
    s_awaddr = addr; s_awvalid = 1'b1;
    s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
    chk({tag, " readies"}, {s_awready, s_wready}, 2'b11);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk({tag, " bvalid"}, s_bvalid, 1'b1);
    chk({tag, " bresp"}, s_bresp, resp);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk({tag, " bvalid drop"}, s_bvalid, 1'b0);
  endtask

  task automatic do_read(input string tag, input logic [7:0] addr, input logic [31:0] data,
                         input logic [1:0] resp);
    s_araddr = addr; s_arvalid = 1'b1;
    chk({tag, " arready"}, s_arready, 1'b1);
    tick();
    s_arvalid = 1'b0;
    chk({tag, " rvalid"}, s_rvalid, 1'b1);
    chk({tag, " rdata"}, s_rdata, data);
    chk({tag, " rresp"}, s_rresp, resp);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    chk({tag, " rvalid drop"}, s_rvalid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst readies", {s_awready, s_wready, s_arready}, 3'b111);
    chk("rst valids", {s_bvalid, s_rvalid}, 2'b00);
    chk("rst rdata", s_rdata, 32'd0);
    chk("rst cfg", {cfg_min ^ cfg_max ^ cfg_offset, cfg_en, cfg_ren, cfg_wen}, '0);

    // Same-cycle AW/W to slice1 MAX
    do_write("w14", 8'h14, 32'hDEAD_BEEF, 4'hF, 2'b00);
    chk("max1", cfg_max[63:32], 32'hDEAD_BEEF);
    do_read("r14", 8'h14, 32'hDEAD_BEEF, 2'b00);

    // W three cycles ahead of AW to slice0 FLAGS
    s_wdata = 32'h5; s_wstrb = 4'b0001; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    chk("wfirst wready low", {s_wready, s_awready, s_bvalid}, 3'b010);
    tick();
    tick();
    chk("wfirst hold", {s_wready, cfg_en[0]}, 2'b00);
    s_awaddr = 8'h0C; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    chk("wfirst flags", {cfg_en[0], cfg_ren[0], cfg_wen[0]}, 3'b101);
    chk("wfirst bresp", {s_bvalid, s_bresp}, 3'b100);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk("wfirst idle", {s_bvalid, s_awready, s_wready}, 3'b011);
    do_read("r0c", 8'h0C, 32'h5, 2'b00);

    // Byte strobes on OFFSET
    do_write("w08a", 8'h08, 32'hFFFF_FFFF, 4'hF, 2'b00);
    do_write("w08b", 8'h08, 32'h0000_1200, 4'b0010, 2'b00);
    chk("off0 strb", cfg_offset[31:0], 32'hFFFF_12FF);
    do_write("w08z", 8'h08, 32'h0, 4'b0000, 2'b00);
    chk("off0 strb0", cfg_offset[31:0], 32'hFFFF_12FF);

    // Out-of-range slice
    do_write("w40", 8'h40, 32'h1234_5678, 4'hF, 2'b10);
    chk("w40 min", cfg_min, 128'h0);
    chk("w40 max", cfg_max, {64'h0, 32'hDEAD_BEEF, 32'h0});
    chk("w40 off", cfg_offset, {96'h0, 32'hFFFF_12FF});
    do_read("r40", 8'h40, 32'h0, 2'b10);

    // Concurrent write/read of slice0 MIN with B and R back-pressured
    do_write("w00a", 8'h00, 32'h1111_1111, 4'hF, 2'b00);
    s_awaddr = 8'h00; s_awvalid = 1'b1; s_wdata = 32'h2222_2222; s_wstrb = 4'hF;
    s_wvalid = 1'b1; s_araddr = 8'h00; s_arvalid = 1'b1;
    tick();
    s_awaddr = 8'h04; s_wdata = 32'h99; s_araddr = 8'h04;
    for (int k = 0; k < 5; k++) begin
      chk("bp valids", {s_bvalid, s_rvalid, s_bresp, s_rresp}, 6'b110000);
      chk("bp rdata", s_rdata, 32'h1111_1111);
      chk("bp readies", {s_awready, s_wready, s_arready}, 3'b000);
      tick();
    end
    chk("bp min0", cfg_min[31:0], 32'h2222_2222);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    s_bready = 1'b1; s_rready = 1'b1;
    tick();
    s_bready = 1'b0; s_rready = 1'b0;
    chk("bp done", {s_bvalid, s_rvalid, s_awready, s_wready, s_arready}, 5'b00111);
    tick();
    chk("bp no stray", {s_bvalid, s_rvalid, cfg_max[31:0]}, 34'h0);
    do_read("r00", 8'h00, 32'h2222_2222, 2'b00);

    // FLAGS upper bits ignored
    do_write("w1c", 8'h1C, 32'hFFFF_FFF8, 4'hF, 2'b00);
    do_read("r1c", 8'h1C, 32'h0, 2'b00);
    do_write("w1c6", 8'h1C, 32'h6, 4'b0001, 2'b00);
    chk("flags vec", {cfg_en, cfg_ren, cfg_wen}, {4'b0001, 4'b0010, 4'b0011});

    // Reset while in write-response state
    s_awaddr = 8'h30; s_awvalid = 1'b1; s_wdata = 32'hABCD; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("wresp pre", {s_bvalid, cfg_min[127:96]}, {1'b1, 32'hABCD});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst mid bvalid", s_bvalid, 1'b0);
    chk("rst mid cfg", {cfg_min | cfg_max | cfg_offset}, 128'h0);
    chk("rst mid flags", {cfg_en, cfg_ren, cfg_wen}, 12'h0);
    chk("rst mid readies", {s_awready, s_wready, s_arready}, 3'b111);

    // Reset discards a latched, uncommitted W
    s_wdata = 32'hAA; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    chk("lat w", s_wready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("lat w cleared", s_wready, 1'b1);
    s_awaddr = 8'h00; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    chk("lat aw only", {s_bvalid, s_awready, s_wready}, 3'b001);
    s_wdata = 32'h33; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    chk("lat commit", {s_bvalid, cfg_min[31:0]}, {1'b1, 32'h33});
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk("lat done", s_bvalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
